access_code_entry: RTL and testbench



---
 rtl/access_pkg.sv | 21 ++
 rtl/bcd_accumulator.sv | 21 ++
 rtl/access_code_entry.sv | 232 +++++++++++++++++++++++
 tb/tb_access_code_entry.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/access_pkg.sv
// access_pkg: shared definitions for the access keypad blocks.
// Holds the controller state encoding and the code/digit widths used by
// access_code_entry and bcd_accumulator (and later the code-provisioning block).
package access_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        FAIL    = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    localparam int CODE_W  = 12;
    localparam int DIGIT_W = 4;

    // Largest legal BCD key value; anything above is a keypad glitch.
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_accumulator.sv
// bcd_accumulator: combinational decimal shift-in, acc_next = acc*10 + digit.
// The multiply by ten is built from two shifts so no multiplier is inferred.
// The result wraps at CODE_W bits; a 3-digit code (max 999) always fits.
// Ports:
//   acc       in  CODE_W   current accumulated value
//   digit     in  DIGIT_W  incoming decimal digit (caller guarantees 0..9)
//   acc_next  out CODE_W   acc*10 + digit, truncated
module bcd_accumulator
    import access_pkg::*;
(
    input  logic [CODE_W-1:0]  acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [CODE_W-1:0]  acc_next
);

    logic [CODE_W-1:0] digit_ext_s;

    assign digit_ext_s = {{(CODE_W-DIGIT_W){1'b0}}, digit};
    assign acc_next    = (acc << 3) + (acc << 1) + digit_ext_s;

endmodule

// File: rtl/access_code_entry.sv
// access_code_entry: keypad-side writer for the employee access comparator.
// Collects decimal digits into a binary code, commits it to the comparator,
// samples the grant result, times the door-unlock window and enforces a
// lockout after MAX_FAIL consecutive failed attempts.
// Optional build macro ACCESS_FIRE_OVERRIDE_EN adds the emergency input,
// which holds the door open and forces the controller idle while asserted.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   key_valid/key_digit digit strobe and BCD value
//   key_enter/key_clear submit / discard strobes
//   emergency           (ACCESS_FIRE_OVERRIDE_EN only) fire/earthquake exit
//   grant               comparator result for access_code
//   access_code         last committed code
//   code_valid          one-cycle pulse on commit
//   door_unlock         door actuator
//   fail_alert          one-cycle pulse per failed attempt
//   locked_out          high during lockout
//   digit_count         digits accepted in the current entry
module access_code_entry
    import access_pkg::*;
#(
    parameter int NUM_DIGITS    = 3,
    parameter int OPEN_CYCLES   = 16,
    parameter int LOCK_CYCLES   = 64,
    parameter int MAX_FAIL      = 3,
    parameter int ENTRY_TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               key_enter,
    input  logic               key_clear,
`ifdef ACCESS_FIRE_OVERRIDE_EN
    input  logic               emergency,
`endif
    input  logic               grant,
    output logic [CODE_W-1:0]  access_code,
    output logic               code_valid,
    output logic               door_unlock,
    output logic               fail_alert,
    output logic               locked_out,
    output logic [2:0]         digit_count
);

    // Timer compare points are "last cycle" values: the timer counts 0..N-1.
    localparam logic [15:0] OPEN_LAST  = 16'(OPEN_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST  = 16'(LOCK_CYCLES - 1);
    localparam logic [15:0] IDLE_LAST  = 16'(ENTRY_TIMEOUT - 1);
    localparam logic [2:0]  NUM_D      = 3'(NUM_DIGITS);
    localparam logic [7:0]  FAIL_LIMIT = 8'(MAX_FAIL);

    state_t             state_r, state_s;
    logic [CODE_W-1:0]  acc_r, acc_s, acc_mul_s;
    logic [2:0]         count_r, count_s;
    logic [15:0]        timer_r, timer_s;
    logic [7:0]         fail_cnt_r, fail_cnt_s;
    logic               load_code_s;
    logic               digit_ok_s;

    logic [CODE_W-1:0]  code_r;
    logic               code_valid_r;
    logic               door_unlock_r;
    logic               fail_alert_r;
    logic               locked_out_r;

    assign digit_ok_s = key_valid && (key_digit <= DIGIT_MAX);

    bcd_accumulator u_bcd_accumulator (
        .acc      (acc_r),
        .digit    (key_digit),
        .acc_next (acc_mul_s)
    );

    // Next-state, datapath and timer update for the entry controller.
    always_comb begin
        state_s     = state_r;
        acc_s       = acc_r;
        count_s     = count_r;
        timer_s     = timer_r;
        fail_cnt_s  = fail_cnt_r;
        load_code_s = 1'b0;

        case (state_r)
            IDLE: begin
                // Clear and enter outrank a coincident digit, and both are no-ops here.
                if (key_clear || key_enter) begin
                    state_s = IDLE;
                end else if (digit_ok_s) begin
                    acc_s   = {{(CODE_W-DIGIT_W){1'b0}}, key_digit};
                    count_s = 3'd1;
                    timer_s = 16'd0;
                    state_s = ENTRY;
                end else begin
                    state_s = IDLE;
                end
            end
            ENTRY: begin
                if (key_clear) begin
                    acc_s   = '0;
                    count_s = 3'd0;
                    state_s = IDLE;
                end else if (key_enter) begin
                    acc_s   = '0;
                    count_s = 3'd0;
                    timer_s = 16'd0;
                    if (count_r == NUM_D) begin
                        load_code_s = 1'b1;
                        state_s     = CHECK;
                    end else begin
                        state_s = FAIL;
                    end
                end else if (digit_ok_s && (count_r < NUM_D)) begin
                    acc_s   = acc_mul_s;
                    count_s = count_r + 3'd1;
                    timer_s = 16'd0;
                end else if (timer_r == IDLE_LAST) begin
                    // Abandoned partial entry: discard silently.
                    acc_s   = '0;
                    count_s = 3'd0;
                    timer_s = 16'd0;
                    state_s = IDLE;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end
            CHECK: begin
                timer_s = 16'd0;
                if (grant) begin
                    fail_cnt_s = 8'd0;
                    state_s    = OPEN;
                end else begin
                    state_s = FAIL;
                end
            end
            OPEN: begin
                if (timer_r == OPEN_LAST) begin
                    timer_s = 16'd0;
                    state_s = IDLE;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end
            FAIL: begin
                fail_cnt_s = fail_cnt_r + 8'd1;
                timer_s    = 16'd0;
                if ((fail_cnt_r + 8'd1) >= FAIL_LIMIT) begin
                    state_s = LOCKOUT;
                end else begin
                    state_s = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer_r == LOCK_LAST) begin
                    timer_s    = 16'd0;
                    fail_cnt_s = 8'd0;
                    state_s    = IDLE;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end
            default: begin
                acc_s      = '0;
                count_s    = 3'd0;
                timer_s    = 16'd0;
                fail_cnt_s = 8'd0;
                state_s    = IDLE;
            end
        endcase

`ifdef ACCESS_FIRE_OVERRIDE_EN
        // Emergency exit overrides everything and leaves a clean idle controller.
        if (emergency) begin
            state_s     = IDLE;
            acc_s       = '0;
            count_s     = 3'd0;
            timer_s     = 16'd0;
            fail_cnt_s  = 8'd0;
            load_code_s = 1'b0;
        end else begin
            load_code_s = load_code_s;
        end
`endif
    end

    // State, datapath and registered outputs; outputs track the next state so
    // each flag is high for exactly the cycles the FSM spends in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            acc_r         <= '0;
            count_r       <= 3'd0;
            timer_r       <= 16'd0;
            fail_cnt_r    <= 8'd0;
            code_r        <= '0;
            code_valid_r  <= 1'b0;
            door_unlock_r <= 1'b0;
            fail_alert_r  <= 1'b0;
            locked_out_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            acc_r         <= acc_s;
            count_r       <= count_s;
            timer_r       <= timer_s;
            fail_cnt_r    <= fail_cnt_s;
            code_valid_r  <= load_code_s;
            door_unlock_r <= (state_s == OPEN);
            fail_alert_r  <= (state_s == FAIL);
            locked_out_r  <= (state_s == LOCKOUT);
            // The comparator only ever sees complete, committed codes.
            if (load_code_s) begin
                code_r <= acc_r;
            end else begin
                code_r <= code_r;
            end
        end
    end

    assign access_code = code_r;
    assign code_valid  = code_valid_r;
    assign fail_alert  = fail_alert_r;
    assign digit_count = count_r;

`ifdef ACCESS_FIRE_OVERRIDE_EN
    assign door_unlock = door_unlock_r | emergency;
    assign locked_out  = locked_out_r & ~emergency;
`else
    assign door_unlock = door_unlock_r;
    assign locked_out  = locked_out_r;
`endif

endmodule

// File: tb/tb_access_code_entry.sv
module tb_access_code_entry;

    localparam int NUM_DIGITS  = 3;
    localparam int OPEN_CYCLES = 16;
    localparam int LOCK_CYCLES = 64;
    localparam int MAX_FAIL    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'd0;
    logic        key_enter = 1'b0;
    logic        key_clear = 1'b0;
    logic        grant;
    logic [11:0] access_code;
    logic        code_valid;
    logic        door_unlock;
    logic        fail_alert;
    logic        locked_out;
    logic [2:0]  digit_count;
`ifdef ACCESS_FIRE_OVERRIDE_EN
    logic        emergency = 1'b0;
`endif

    // Comparator model: matches one stored employee code.
    logic [11:0] secret = 12'd0;
    assign grant = (access_code == secret);

    int checks = 0;
    int errors = 0;
    int fail_cnt_m = 0;
    int gap_max = 0;
    int keys_q[$];

    always #5 clk = ~clk;

    access_code_entry dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .key_enter   (key_enter),
        .key_clear   (key_clear),
`ifdef ACCESS_FIRE_OVERRIDE_EN
        .emergency   (emergency),
`endif
        .grant       (grant),
        .access_code (access_code),
        .code_valid  (code_valid),
        .door_unlock (door_unlock),
        .fail_alert  (fail_alert),
        .locked_out  (locked_out),
        .digit_count (digit_count)
    );

    task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_digit(input int d);
        key_valid = 1'b1;
        key_digit = d[3:0];
        tick();
        key_valid = 1'b0;
        key_digit = 4'd0;
        repeat ($urandom_range(0, gap_max)) tick();
    endtask

    task automatic press_enter();
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
    endtask

    task automatic press_clear();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
    endtask

    task automatic random_keys();
        key_valid = 1'($urandom % 2);
        key_digit = 4'($urandom % 10);
        key_enter = ($urandom % 4) == 0;
        key_clear = ($urandom % 5) == 0;
    endtask

    task automatic idle_keys();
        key_valid = 1'b0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        key_digit = 4'd0;
    endtask

    // Door window: count high cycles while hammering the keypad.
    task automatic door_pulse(input string tag);
        int n = 0;
        bit stray = 0;
        while (door_unlock === 1'b1 && n < 200) begin
            n++;
            random_keys();
            tick();
            if (code_valid || fail_alert || locked_out) stray = 1;
        end
        idle_keys();
        check(tag, "open_len", n, OPEN_CYCLES);
        check(tag, "open_stray", stray, 0);
        check(tag, "open_count", digit_count, 0);
    endtask

    // Lockout window: keys must be ignored, door must stay shut.
    task automatic lock_pulse(input string tag);
        int n = 0;
        bit stray = 0;
        while (locked_out === 1'b1 && n < 300) begin
            n++;
            random_keys();
            tick();
            if (code_valid || fail_alert || door_unlock) stray = 1;
        end
        idle_keys();
        check(tag, "lock_len", n, LOCK_CYCLES);
        check(tag, "lock_stray", stray, 0);
        check(tag, "lock_count", digit_count, 0);
    endtask

    task automatic after_fail(input string tag);
        fail_cnt_m++;
        tick();
        check(tag, "alert_once", fail_alert, 0);
        if (fail_cnt_m >= MAX_FAIL) begin
            check(tag, "locked", locked_out, 1);
            lock_pulse(tag);
            fail_cnt_m = 0;
        end else begin
            check(tag, "not_locked", locked_out, 0);
            check(tag, "fail_count", digit_count, 0);
        end
    endtask

    // One attempt from IDLE using keys_q. mode: 0 keep secret, 1 force match, 2 force mismatch.
    task automatic attempt(input string tag, input int mode);
        int val = 0;
        int cnt = 0;
        bit gr;
        foreach (keys_q[i]) begin
            if (keys_q[i] <= 9 && cnt < NUM_DIGITS) begin
                val = (val * 10 + keys_q[i]) % 4096;
                cnt++;
            end
        end
        if (mode == 1) secret = 12'(val);
        else if (mode == 2) secret = 12'(val) ^ 12'h001;
        else secret = secret;
        foreach (keys_q[i]) press_digit(keys_q[i]);
        check(tag, "count", digit_count, cnt);
        press_enter();
        if (cnt == NUM_DIGITS) begin
            check(tag, "code_valid", code_valid, 1);
            check(tag, "access_code", access_code, val);
            gr = (val == int'(secret));
            tick();
            check(tag, "cv_pulse", code_valid, 0);
            if (gr) begin
                check(tag, "door", door_unlock, 1);
                check(tag, "no_alert", fail_alert, 0);
                fail_cnt_m = 0;
                door_pulse(tag);
            end else begin
                check(tag, "alert", fail_alert, 1);
                check(tag, "door_shut", door_unlock, 0);
                after_fail(tag);
            end
        end else if (cnt == 0) begin
            check(tag, "idle_cv", code_valid, 0);
            check(tag, "idle_alert", fail_alert, 0);
        end else begin
            check(tag, "short_cv", code_valid, 0);
            check(tag, "short_alert", fail_alert, 1);
            after_fail(tag);
        end
        keys_q.delete();
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset", "access_code", access_code, 0);
        check("reset", "code_valid", code_valid, 0);
        check("reset", "door", door_unlock, 0);
        check("reset", "alert", fail_alert, 0);
        check("reset", "locked", locked_out, 0);
        check("reset", "count", digit_count, 0);

        // Correct code opens the door.
        secret = 12'd731;
        keys_q = '{7, 3, 1};
        attempt("grant731", 0);

        // Three wrong full codes lock the keypad.
        for (int k = 0; k < 3; k++) begin
            keys_q = '{1, 2, 3};
            attempt("wrong123", 0);
        end

        // Clear discards a partial entry without a failure.
        press_digit(2);
        press_digit(9);
        check("clear", "count_pre", digit_count, 2);
        press_clear();
        check("clear", "count_post", digit_count, 0);
        check("clear", "alert", fail_alert, 0);
        secret = 12'd294;
        keys_q = '{2, 9, 4};
        attempt("after_clear", 0);

        // Inter-key timeout: 32 idle cycles drop the entry, enter is then ignored.
        press_digit(3);
        check("timeout", "count1", digit_count, 1);
        repeat (31) tick();
        check("timeout", "still_entry", digit_count, 1);
        tick();
        check("timeout", "dropped", digit_count, 0);
        press_enter();
        check("timeout", "cv", code_valid, 0);
        check("timeout", "alert", fail_alert, 0);
        tick();
        check("timeout", "alert_late", fail_alert, 0);

        // Out-of-range digit is ignored mid-entry.
        secret = 12'd337;
        keys_q = '{3, 10, 3, 7};
        attempt("bad_digit", 0);

        // Randomised attempts: short, long, invalid digits, matches and misses.
        gap_max = 2;
        for (int r = 0; r < 14; r++) begin
            int n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                if ($urandom % 10 == 0) keys_q.push_back(int'($urandom_range(10, 15)));
                else keys_q.push_back(int'($urandom_range(0, 9)));
            end
            attempt("rand", ($urandom % 2 == 0) ? 1 : 2);
        end
        gap_max = 0;

        // Reset during the door window.
        secret = 12'd731;
        press_digit(7);
        press_digit(3);
        press_digit(1);
        press_enter();
        tick();
        check("rst_open", "door_on", door_unlock, 1);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_open", "door", door_unlock, 0);
        check("rst_open", "count", digit_count, 0);
        check("rst_open", "access_code", access_code, 0);
        check("rst_open", "locked", locked_out, 0);
        fail_cnt_m = 0;
        tick();
        check("rst_open", "door_after", door_unlock, 0);

`ifdef ACCESS_FIRE_OVERRIDE_EN
        // Emergency exit during lockout.
        keys_q = '{1};
        attempt("em_f1", 2);
        keys_q = '{1};
        attempt("em_f2", 2);
        press_digit(1);
        press_enter();
        check("emerg", "alert", fail_alert, 1);
        tick();
        check("emerg", "locked", locked_out, 1);
        repeat (10) tick();
        emergency = 1'b1;
        #1;
        check("emerg", "door_comb", door_unlock, 1);
        check("emerg", "unlocked_comb", locked_out, 0);
        repeat (3) tick();
        check("emerg", "door_held", door_unlock, 1);
        check("emerg", "unlocked", locked_out, 0);
        emergency = 1'b0;
        #1;
        check("emerg", "door_release", door_unlock, 0);
        check("emerg", "locked_release", locked_out, 0);
        fail_cnt_m = 0;
        tick();
        keys_q = '{1, 9, 1};
        attempt("em_resume", 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
